// File: rtl/finger_scan_controller.sv
// -----------------------------------------------------------------------------
// finger_scan_controller
//
// Purpose:
//   Time-multiplexes one shared flex-sensor comparator across the five finger
//   channels (thumb, index, middle, ring, pinky) through an analog mux.
//   For each finger the mux is selected and given time to settle, then the
//   comparator is sampled once.
//   After all five fingers are sampled, the raw frame is committed.
//   A frame must repeat identically for STABLE_FRAMES consecutive scans before
//   the debounced status outputs take its value.
//   An idle gap with the sensor excitation off separates successive frames.
//
// Parameters:
//   SETTLE_CYCLES - cycles the mux is held enabled before each sample (>=1)
//   STABLE_FRAMES - identical consecutive frames needed to update status (>=1)
//   SCAN_GAP      - idle cycles between frames with mux_en low (>=1)
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   enable         in   run continuous scanning while high
//   sens_bent      in   shared comparator output for the selected finger
//   mux_sel[2:0]   out  selected finger, 0=thumb .. 4=pinky
//   mux_en         out  analog mux / sensor excitation enable
//   *_status       out  debounced bent flags, one per finger
//   frame_valid    out  one-cycle pulse per committed frame
//   status_changed out  one-cycle pulse when any *_status output changes
//   busy           out  high whenever the scanner is not idle
// -----------------------------------------------------------------------------
module finger_scan_controller #(
  parameter int SETTLE_CYCLES = 8,
  parameter int STABLE_FRAMES = 3,
  parameter int SCAN_GAP      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sens_bent,
  output logic [2:0] mux_sel,
  output logic       mux_en,
  output logic       thumb_status,
  output logic       index_status,
  output logic       middle_status,
  output logic       ring_status,
  output logic       pinky_status,
  output logic       frame_valid,
  output logic       status_changed,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    COMMIT = 3'd3,
    GAP    = 3'd4
  } state_t;

  // One counter serves both the settle and the gap intervals, since they
  // never overlap; it is sized for the longer of the two.
  localparam int CNT_MAX = (SETTLE_CYCLES > SCAN_GAP) ? SETTLE_CYCLES : SCAN_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(STABLE_FRAMES + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(SCAN_GAP - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_FRAMES);
  localparam logic [2:0]    LAST_FINGER = 3'd4;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      mux_sel_q, mux_sel_d;
  logic            mux_en_q, mux_en_d;
  logic            busy_q, busy_d;
  logic [4:0]      raw_q, raw_d;
  logic [4:0]      cand_q, cand_d;
  logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
  logic [4:0]      status_q, status_d;
  logic            frame_valid_q, frame_valid_d;
  logic            status_changed_q, status_changed_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      mux_sel_q        <= '0;
      mux_en_q         <= 1'b0;
      busy_q           <= 1'b0;
      raw_q            <= '0;
      cand_q           <= '0;
      stable_cnt_q     <= '0;
      status_q         <= '0;
      frame_valid_q    <= 1'b0;
      status_changed_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      mux_sel_q        <= mux_sel_d;
      mux_en_q         <= mux_en_d;
      busy_q           <= busy_d;
      raw_q            <= raw_d;
      cand_q           <= cand_d;
      stable_cnt_q     <= stable_cnt_d;
      status_q         <= status_d;
      frame_valid_q    <= frame_valid_d;
      status_changed_q <= status_changed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    mux_sel_d        = mux_sel_q;
    raw_d            = raw_q;
    cand_d           = cand_q;
    stable_cnt_d     = stable_cnt_q;
    status_d         = status_q;
    frame_valid_d    = 1'b0;
    status_changed_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = SETTLE;
          cnt_d     = '0;
          mux_sel_d = '0;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SAMPLE: begin
        // Decoded write keeps the index in range even if mux_sel were corrupt.
        for (int i = 0; i < 5; i++) begin
          if (mux_sel_q == 3'(i)) begin
            raw_d[i] = sens_bent;
          end
        end
        if (mux_sel_q == LAST_FINGER) begin
          state_d   = COMMIT;
          mux_sel_d = '0;
        end else begin
          state_d   = SETTLE;
          mux_sel_d = mux_sel_q + 3'd1;
          cnt_d     = '0;
        end
      end

      COMMIT: begin
        // After this cycle the candidate always equals the frame just taken;
        // only the run length depends on whether it repeated.
        cand_d = raw_q;
        if (raw_q == cand_q) begin
          stable_cnt_d = (stable_cnt_q == STABLE_MAX) ? STABLE_MAX
                                                      : stable_cnt_q + SW'(1);
        end else begin
          stable_cnt_d = SW'(1);
        end
        if ((stable_cnt_d == STABLE_MAX) && (raw_q != status_q)) begin
          status_d         = raw_q;
          status_changed_d = 1'b1;
        end
        frame_valid_d = 1'b1;
        state_d       = GAP;
        cnt_d         = '0;
      end

      GAP: begin
        // enable is only consulted on the final gap cycle.
        if (cnt_q == GAP_LAST) begin
          cnt_d     = '0;
          mux_sel_d = '0;
          state_d   = enable ? SETTLE : IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        mux_sel_d = '0;
      end
    endcase

    // Registered from the next state so these flags line up with state_q.
    mux_en_d = (state_d == SETTLE) || (state_d == SAMPLE);
    busy_d   = (state_d != IDLE);
  end

  assign mux_sel        = mux_sel_q;
  assign mux_en         = mux_en_q;
  assign busy           = busy_q;
  assign frame_valid    = frame_valid_q;
  assign status_changed = status_changed_q;
  assign thumb_status   = status_q[0];
  assign index_status   = status_q[1];
  assign middle_status  = status_q[2];
  assign ring_status    = status_q[3];
  assign pinky_status   = status_q[4];

endmodule

// File: doc/finger_scan_controller.md
Name: finger_scan_controller

Overview:
Sequences one shared flex-sensor comparator across the five finger channels (thumb..pinky) through an analog mux. It waits for the mux to settle, samples each finger, and debounces whole frames across consecutive scans. It then presents stable thumb/index/middle/ring/pinky status bits, plus strobes, to the downstream sign identification logic.

Parameters:
SETTLE_CYCLES, 8, cycles mux_sel is held with mux_en=1 before each sample (>=1)
STABLE_FRAMES, 3, consecutive identical raw frames required before outputs update (>=1)
SCAN_GAP, 16, idle cycles between frames, mux_en=0 (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
enable  input  1  run continuous scanning while high
sens_bent  input  1  shared comparator output for the selected finger; 1 = bent
mux_sel  output  3  selected finger: 0 thumb, 1 index, 2 middle, 3 ring, 4 pinky
mux_en  output  1  analog mux / sensor excitation enable
thumb_status  output  1  debounced thumb bent
index_status  output  1  debounced index bent
middle_status  output  1  debounced middle bent
ring_status  output  1  debounced ring bent
pinky_status  output  1  debounced pinky bent
frame_valid  output  1  one-cycle pulse per completed frame
status_changed  output  1  one-cycle pulse when any *_status output changes
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset state: state=IDLE, mux_sel=0, mux_en=0, all *_status=0, frame_valid=0, status_changed=0, busy=0; raw[4:0]=0, candidate[4:0]=0, stable_cnt=0, settle/gap counters=0.
- FSM: IDLE, SETTLE, SAMPLE, COMMIT, GAP.
- IDLE: mux_en=0. If enable=1, go to SETTLE with mux_sel=0 and counter=0.
- SETTLE: mux_en=1. Held for exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: one cycle, mux_en=1. raw[mux_sel] <= sens_bent.
  - If mux_sel==4, go to COMMIT.
  - Otherwise mux_sel increments and state returns to SETTLE with counter cleared.
- COMMIT: one cycle, mux_en=0, mux_sel returns to 0.
  - If raw==candidate: stable_cnt increments, saturating at STABLE_FRAMES.
  - Otherwise: candidate<=raw and stable_cnt<=1.
  - If the resulting stable_cnt==STABLE_FRAMES and candidate differs from the current status vector: status vector <= candidate, and status_changed pulses.
  - frame_valid pulses on every commit.
  - Both pulses and the new status values appear in the cycle after COMMIT.
  - Next state is GAP.
- GAP: mux_en=0 for SCAN_GAP cycles. Then go to SETTLE (mux_sel=0) if enable=1, else IDLE.
- Status vector bit mapping: [0]=thumb .. [4]=pinky.
- Timing with defaults:
  - enable seen in IDLE at cycle 0 → finger k sampled at cycle 9+9k → COMMIT at cycle 46 → frame_valid at cycle 47.
  - Frame period under continuous enable = 5*(SETTLE_CYCLES+1)+1+SCAN_GAP = 62 cycles.
- Enable deasserted mid-frame: the current frame completes (including COMMIT and GAP), then IDLE. No partial frame is ever committed.
- enable toggled within GAP: only its value at the end of GAP matters.
- rst mid-frame: immediate return to reset state on the next edge. raw, candidate, stable_cnt and outputs are cleared, and no pulses are emitted.
- sens_bent is sampled only in SAMPLE and ignored in all other states.
- mux_sel never exceeds 4.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then enable=0 for 100 cycles → all outputs 0, busy=0, no pulses.
- Timing: enable=1 from cycle 0, sens_bent=0 → mux_sel steps 0..4, each held 9 cycles; frame_valid at cycles 47, 109, 171; status_changed never asserts; mux_en=0 during COMMIT/GAP.
- Debounce: drive sens_bent=1 only while mux_sel∈{1,2} → raw=5'b00110. index/middle_status go high together with the 3rd frame_valid (cycle 171), with one status_changed pulse. Dropping back to all-open updates the outputs 3 frames later.
- Glitch rejection: pattern 5'b11111 for 2 frames, then 5'b00000 → status stays 0, status_changed never asserts, stable_cnt restarts at 1.
- Mid-operation: deassert enable during finger 2 → frame completes, frame_valid pulses once, GAP elapses, IDLE. Assert rst during SETTLE of finger 3 → next cycle everything returns to reset values.
- Parameters: SETTLE_CYCLES=1, STABLE_FRAMES=1, SCAN_GAP=1 → period 12 cycles; outputs follow every frame immediately.
